// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: bubble encoding, reset vector and fetch FSM encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_HOLD    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return {i_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register with flush (highest priority), load and implicit hold.
module if_id_pipeline_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_valid;

    // A flush keeps the stale pc; only valid and the instruction word matter downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= 32'h0000_0000;
            r_instruction <= BUBBLE_INSTR;
            r_valid       <= 1'b0;
        end else if (i_flush) begin
            r_instruction <= BUBBLE_INSTR;
            r_valid       <= 1'b0;
        end else if (i_load) begin
            r_pc          <= i_pc;
            r_instruction <= i_instruction;
            r_valid       <= i_valid;
        end
    end

    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, runs the imem read handshake and fills the IF/ID register.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        branch_jump_mux_signal,
    input  logic [31:0] Branch_jump_PC_OUT,
    input  logic        stall,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    fetch_state_t r_state, w_next_state;
    logic [31:0]  r_pc, w_next_pc;
    logic [31:0]  r_req_addr, w_next_req_addr;
    logic [31:0]  r_buf_pc, w_next_buf_pc;
    logic [31:0]  r_buf_instr, w_next_buf_instr;

    logic         w_ifid_load;
    logic         w_ifid_flush;
    logic [31:0]  w_ifid_pc;
    logic [31:0]  w_ifid_instr;
    logic         w_ifid_valid;

    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_complete;

    assign w_target     = word_align(Branch_jump_PC_OUT);
    assign w_pc_plus4   = r_pc + 32'd4;
    assign imem_read    = (r_state == FETCH_REQ) || (r_state == FETCH_DISCARD);
    assign imem_address = r_req_addr;
    assign w_complete   = imem_read && !imem_busywait;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= FETCH_IDLE;
            r_pc        <= RESET_VECTOR;
            r_req_addr  <= RESET_VECTOR;
            r_buf_pc    <= 32'h0000_0000;
            r_buf_instr <= NOP_INSTR;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_req_addr  <= w_next_req_addr;
            r_buf_pc    <= w_next_buf_pc;
            r_buf_instr <= w_next_buf_instr;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_pc        = r_pc;
        w_next_req_addr  = r_req_addr;
        w_next_buf_pc    = r_buf_pc;
        w_next_buf_instr = r_buf_instr;
        w_ifid_load      = 1'b0;
        w_ifid_flush     = 1'b0;
        w_ifid_pc        = r_req_addr;
        w_ifid_instr     = NOP_INSTR;
        w_ifid_valid     = 1'b0;

        unique case (r_state)
            FETCH_IDLE: begin
                w_next_state    = FETCH_REQ;
                w_next_req_addr = r_pc;
            end
            FETCH_REQ: begin
                if (branch_jump_mux_signal) begin
                    w_next_pc        = w_target;
                    w_ifid_flush     = 1'b1;
                    w_next_buf_pc    = 32'h0000_0000;
                    w_next_buf_instr = NOP_INSTR;
                    // A stalled request cannot be withdrawn; it is waited out in DISCARD.
                    if (imem_busywait) begin
                        w_next_state = FETCH_DISCARD;
                    end else begin
                        w_next_req_addr = w_target;
                    end
                end else if (w_complete) begin
                    w_next_pc = w_pc_plus4;
                    if (!stall) begin
                        w_ifid_load     = 1'b1;
                        w_ifid_instr    = imem_readdata;
                        w_ifid_valid    = 1'b1;
                        w_next_req_addr = w_pc_plus4;
                    end else begin
                        w_next_buf_pc    = r_req_addr;
                        w_next_buf_instr = imem_readdata;
                        w_next_state     = FETCH_HOLD;
                    end
                end else if (!stall) begin
                    w_ifid_load = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (branch_jump_mux_signal) begin
                    w_next_pc        = w_target;
                    w_ifid_flush     = 1'b1;
                    w_next_buf_pc    = 32'h0000_0000;
                    w_next_buf_instr = NOP_INSTR;
                    w_next_req_addr  = w_target;
                    w_next_state     = FETCH_REQ;
                end else if (!stall) begin
                    w_ifid_load     = 1'b1;
                    w_ifid_pc       = r_buf_pc;
                    w_ifid_instr    = r_buf_instr;
                    w_ifid_valid    = 1'b1;
                    w_next_req_addr = r_pc;
                    w_next_state    = FETCH_REQ;
                end
            end
            FETCH_DISCARD: begin
                if (branch_jump_mux_signal) begin
                    w_next_pc = w_target;
                end
                if (!imem_busywait) begin
                    w_next_state    = FETCH_REQ;
                    w_next_req_addr = branch_jump_mux_signal ? w_target : r_pc;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
            end
        endcase
    end

    if_id_pipeline_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id (
        .i_clk         (CLK),
        .i_rst_n       (RESET),
        .i_load        (w_ifid_load),
        .i_flush       (w_ifid_flush),
        .i_pc          (w_ifid_pc),
        .i_instruction (w_ifid_instr),
        .i_valid       (w_ifid_valid),
        .o_pc          (if_id_pc),
        .o_instruction (if_id_instruction),
        .o_valid       (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle table plus randomized run scored against an instruction-stream model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        CLK;
    logic        RESET;
    logic        branch_jump_mux_signal;
    logic [31:0] Branch_jump_PC_OUT;
    logic        stall;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;

    int n_checks = 0;
    int n_err    = 0;

    instruction_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .NOP_INSTR    (NOP)
    ) dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .branch_jump_mux_signal (branch_jump_mux_signal),
        .Branch_jump_PC_OUT     (Branch_jump_PC_OUT),
        .stall                  (stall),
        .imem_address           (imem_address),
        .imem_read              (imem_read),
        .imem_readdata          (imem_readdata),
        .imem_busywait          (imem_busywait),
        .if_id_pc               (if_id_pc),
        .if_id_instruction      (if_id_instruction),
        .if_id_valid            (if_id_valid)
    );

    // Memory returns a tag derived from the address so data can be tied to its pc.
    assign imem_readdata = imem_address ^ SALT;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst_pulse;
        logic        redir;
        logic [31:0] tgt;
        logic        stl;
        logic        busy;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_read"},  {31'b0, imem_read},   32'd0);
        chk({tag, "_addr"},  imem_address,         32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
        chk({tag, "_pc"},    if_id_pc,             32'h0);
        chk({tag, "_instr"}, if_id_instruction,    NOP);
    endtask

    task automatic add(input logic rp, input logic r, input logic [31:0] t, input logic s,
                       input logic b, input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst_pulse = rp; v.redir = r; v.tgt = t; v.stl = s; v.busy = b;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    initial begin
        logic [31:0] exp_pc;
        logic        pend_busy;
        logic [31:0] pend_addr;
        int          n_consumed;
        logic        s, r, b;
        logic [31:0] t;

        RESET = 1'b0;
        branch_jump_mux_signal = 1'b0;
        Branch_jump_PC_OUT = 32'h0;
        stall = 1'b0;
        imem_busywait = 1'b0;

        //   rp r  tgt            s  b   read addr          valid pc            instr
        add(0, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,        NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h4,        1, 32'h0,        d(32'h0));
        add(0, 0, 32'h0,        0, 0,   1, 32'h8,        1, 32'h4,        d(32'h4));
        add(0, 0, 32'h0,        0, 0,   1, 32'hC,        1, 32'h8,        d(32'h8));
        add(0, 1, 32'h100,      0, 0,   1, 32'h100,      0, 32'h8,        NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h104,      1, 32'h100,      d(32'h100));
        add(0, 1, 32'hF,        0, 0,   1, 32'hC,        0, 32'h100,      NOP);
        add(0, 1, 32'h40,       0, 1,   1, 32'hC,        0, 32'h100,      NOP);
        add(0, 0, 32'h0,        0, 1,   1, 32'hC,        0, 32'h100,      NOP);
        add(0, 0, 32'h0,        0, 1,   1, 32'hC,        0, 32'h100,      NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h40,       0, 32'h100,      NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h44,       1, 32'h40,       d(32'h40));
        add(0, 1, 32'hC,        0, 0,   1, 32'hC,        0, 32'h40,       NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h10,       1, 32'hC,        d(32'hC));
        add(0, 0, 32'h0,        1, 0,   0, 32'h10,       1, 32'hC,        d(32'hC));
        add(0, 0, 32'h0,        1, 0,   0, 32'h10,       1, 32'hC,        d(32'hC));
        add(0, 0, 32'h0,        1, 0,   0, 32'h10,       1, 32'hC,        d(32'hC));
        add(0, 0, 32'h0,        1, 0,   0, 32'h10,       1, 32'hC,        d(32'hC));
        add(0, 0, 32'h0,        0, 0,   1, 32'h14,       1, 32'h10,       d(32'h10));
        add(0, 0, 32'h0,        0, 0,   1, 32'h18,       1, 32'h14,       d(32'h14));
        add(0, 0, 32'h0,        1, 0,   0, 32'h18,       1, 32'h14,       d(32'h14));
        add(0, 1, 32'h200,      1, 0,   1, 32'h200,      0, 32'h14,       NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h204,      1, 32'h200,      d(32'h200));
        add(0, 0, 32'h0,        0, 1,   1, 32'h204,      0, 32'h204,      NOP);
        add(0, 0, 32'h0,        1, 1,   1, 32'h204,      0, 32'h204,      NOP);
        add(1, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,        NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h4,        1, 32'h0,        d(32'h0));
        add(0, 1, 32'hFFFF_FFFC, 0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0,       NOP);
        add(0, 0, 32'h0,        0, 0,   1, 32'h0,        1, 32'hFFFF_FFFC, d(32'hFFFF_FFFC));

        repeat (2) @(negedge CLK);
        chk_reset_values("reset_init");
        RESET = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_pulse) begin
                // Reset lands while a request is still waiting on busywait.
                #2 RESET = 1'b0;
                #1 chk_reset_values($sformatf("reset_async_row%0d", i));
                @(negedge CLK);
                RESET = 1'b1;
            end
            branch_jump_mux_signal = vecs[i].redir;
            Branch_jump_PC_OUT     = vecs[i].tgt;
            stall                  = vecs[i].stl;
            imem_busywait          = vecs[i].busy;
            @(posedge CLK);
            #1;
            chk($sformatf("row%0d_read", i),  {31'b0, imem_read},   {31'b0, vecs[i].e_read});
            chk($sformatf("row%0d_addr", i),  imem_address,         vecs[i].e_addr);
            chk($sformatf("row%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("row%0d_pc", i),    if_id_pc,             vecs[i].e_pc);
            chk($sformatf("row%0d_instr", i), if_id_instruction,    vecs[i].e_instr);
            @(negedge CLK);
        end

        // Random run: every instruction the decoder consumes must follow program order.
        RESET = 1'b0;
        branch_jump_mux_signal = 1'b0;
        stall = 1'b0;
        imem_busywait = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        exp_pc     = 32'h0000_0000;
        pend_busy  = 1'b0;
        pend_addr  = 32'h0;
        n_consumed = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (pend_busy) begin
                chk("hold_read", {31'b0, imem_read}, 32'd1);
                chk("hold_addr", imem_address, pend_addr);
            end
            chk("addr_align", {30'b0, imem_address[1:0]}, 32'd0);

            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            r = (cyc >= 2) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                t = $urandom & 32'h0000_0FFF;

            branch_jump_mux_signal = r;
            Branch_jump_PC_OUT     = t;
            stall                  = s;
            imem_busywait          = b;

            if (if_id_valid && !s && !r) begin
                chk("sb_pc", if_id_pc, exp_pc);
                chk("sb_instr", if_id_instruction, d(if_id_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (r)
                exp_pc = {t[31:2], 2'b00};

            pend_busy = imem_read && b;
            pend_addr = imem_address;
            @(negedge CLK);
        end
        chk("progress", (n_consumed > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- PC-generation and instruction-fetch stage of the 5-stage RV32I pipeline.
- Consumes the branch/jump unit's taken flag and target address. Owns the PC register and drives the instruction-memory read handshake.
- Produces the IF/ID pipeline register (PC, instruction, valid).
- Handles redirect flushes, hazard stalls and in-flight memory responses that must be discarded.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush/bubble

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
branch_jump_mux_signal  input  1  redirect request from branch/jump unit, sampled at rising edge
Branch_jump_PC_OUT  input  32  redirect target; bits [1:0] forced to 0 internally
stall  input  1  hazard-unit stall: hold PC and IF/ID
imem_address  output  32  word-aligned fetch address
imem_read  output  1  read request
imem_readdata  input  32  instruction; valid in a cycle where imem_read=1 and imem_busywait=0
imem_busywait  input  1  memory not ready; request and address must be held while high
if_id_pc  output  32  PC of the instruction in IF/ID
if_id_instruction  output  32  instruction in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction

Behaviour:
Reset (RESET=0, asynchronous):
- PC=RESET_VECTOR, state=IDLE, imem_read=0, imem_address=RESET_VECTOR.
- if_id_pc=0, if_id_instruction=NOP_INSTR, if_id_valid=0, holding buffer empty.
- Reset mid-transaction abandons the request; no handshake completion is required.

States: IDLE, REQ, HOLD, DISCARD.
- IDLE: imem_read=0; moves to REQ at the next edge. Entered only from reset.
- REQ: imem_read=1, imem_address=req_addr.
  - req_addr loads from PC on entry and after each completed access; it is stable while busywait is high.
- Completion is an edge where imem_read=1 and imem_busywait=0.

Priority at each edge: redirect > completion > stall.

Redirect (branch_jump_mux_signal=1, any state except IDLE):
- PC<=target.
- IF/ID flushed: valid=0, instruction=NOP_INSTR.
- Holding buffer cleared.
- If REQ with busywait=1: go to DISCARD.
- Otherwise (REQ completing, or HOLD): any returned data is dropped; go to REQ with req_addr=target.

REQ, completion, no redirect:
- stall=0: IF/ID<={req_addr, imem_readdata, 1}; PC<=PC+4; stay in REQ.
- stall=1: buffer<={req_addr, imem_readdata}; PC<=PC+4; IF/ID held; go to HOLD.

REQ, no completion:
- stall=0: IF/ID<=bubble (valid=0, NOP_INSTR, pc=req_addr).
- stall=1: IF/ID held.

HOLD:
- imem_read=0.
- stall=0: IF/ID<=buffer with valid=1; go to REQ.
- stall=1: remain in HOLD.

DISCARD:
- imem_read=1 at the old req_addr until busywait=0.
- At that edge, data is dropped and the state moves to REQ with req_addr=PC.
- A further redirect in DISCARD only updates PC.
- IF/ID stays a bubble.

Arithmetic and throughput:
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Throughput with zero-wait memory is 1 instruction/cycle.
- The first instruction appears in IF/ID at the 2nd rising edge after reset deassertion.

Decomposition:
- Shared riscv_pkg holds: NOP_INSTR, RESET_VECTOR default, fetch state encoding (2-bit: IDLE=0, REQ=1, HOLD=2, DISCARD=3).
- One sub-module: if_id_pipeline_reg, the IF/ID register with load/hold/flush controls, reused by the later ID/EX design.

Test Plan:
1. Reset release, zero-wait memory returning addr^32'hA5A5_0000 -> IF/ID shows pc 0, 4, 8 on consecutive cycles, valid=1 from the 2nd edge.
2. Redirect to 32'h0000_0100 while IF/ID holds pc 8 -> next cycle valid=0 with NOP, imem_address=0x100; pc 0x100 becomes valid one cycle later.
3. Memory busywait 3 cycles on addr 0xC with redirect to 0x40 in the 1st wait cycle -> imem_address stays 0xC until busywait falls; that data never reaches IF/ID; next request is 0x40.
4. stall held 4 cycles while the 0x10 access completes -> IF/ID keeps the pc 0xC instruction, imem_read=0 in HOLD; after release the pc 0x10 instruction appears valid with no duplicate or loss.
5. Redirect and stall asserted together in HOLD -> buffer cleared, IF/ID flushed, target fetched next.
6. Assert RESET=0 mid-busywait -> all outputs take reset values immediately; fetch restarts at RESET_VECTOR.
